// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic-array result serializer.
// State encodings are plain 2-bit constants so older tools can consume them.
package sys_array_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_HEADER   = 2'd1;
    localparam state_t ST_PAYLOAD  = 2'd2;
    localparam state_t ST_CHECKSUM = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    function automatic int bytes_per_elem(input int data_width);
        return (2 * data_width + 7) / 8;
    endfunction

    function automatic int n_payload(input int data_width, input int rows, input int cols);
        return rows * cols * bytes_per_elem(data_width);
    endfunction

    // Counter width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_array_result_serializer.sv
// Captures a finished result matrix and streams it as a framed byte sequence:
// header, row-major MSB-first payload, then XOR checksum of the payload.
module sys_array_result_serializer
    import sys_array_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         ARRAY_W_W  = 2,
    parameter int         ARRAY_A_L  = 2,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   res_valid,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0]  res_data,
    output logic [7:0]                                             tx_data,
    output logic                                                   tx_valid,
    input  logic                                                   tx_ready,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   overrun
);

    localparam int EW        = 2 * DATA_WIDTH;
    localparam int BPE       = bytes_per_elem(DATA_WIDTH);
    localparam int N_ELEM    = ARRAY_W_W * ARRAY_A_L;
    localparam int N_PAYLOAD = n_payload(DATA_WIDTH, ARRAY_W_W, ARRAY_A_L);
    localparam int ELEM_W    = idx_width(N_ELEM);
    localparam int BIDX_W    = idx_width(BPE);
    localparam int PIDX_W    = idx_width(N_PAYLOAD);

    typedef logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][EW-1:0] matrix_t;

    state_t              state_q, state_d;
    matrix_t             snap_q, snap_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic [7:0]          csum_q, csum_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic [7:0]          payload_bytes [N_PAYLOAD];
    logic [PIDX_W-1:0]   sel_idx;
    logic [7:0]          sel_byte;
    logic                handshake;

    // Flatten the snapshot into transmit order: byte 0 of each element is its MSB.
    for (genvar gi = 0; gi < ARRAY_W_W; gi++) begin : g_row
        for (genvar gj = 0; gj < ARRAY_A_L; gj++) begin : g_col
            logic [BPE*8-1:0] elem_pad;
            assign elem_pad = (BPE*8)'(snap_q[gi][gj]);
            for (genvar gb = 0; gb < BPE; gb++) begin : g_byte
                assign payload_bytes[(gi*ARRAY_A_L+gj)*BPE+gb] = elem_pad[(BPE-1-gb)*8 +: 8];
            end
        end
    end

    assign sel_idx   = PIDX_W'(elem_q) * PIDX_W'(BPE) + PIDX_W'(bidx_q);
    assign sel_byte  = payload_bytes[sel_idx];
    assign tx_valid  = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign handshake = tx_valid && tx_ready;
    assign done      = done_q;
    assign overrun   = overrun_q;

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_HEADER:   tx_data = HEADER;
            ST_PAYLOAD:  tx_data = sel_byte;
            ST_CHECKSUM: tx_data = csum_q;
            default:     tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        elem_d    = elem_q;
        bidx_d    = bidx_q;
        csum_d    = csum_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (res_valid) begin
                    snap_d  = res_data;
                    csum_d  = 8'h00;
                    elem_d  = '0;
                    bidx_d  = '0;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (res_valid) overrun_d = 1'b1;
                if (handshake) begin
                    elem_d  = '0;
                    bidx_d  = '0;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (res_valid) overrun_d = 1'b1;
                if (handshake) begin
                    csum_d = csum_q ^ sel_byte;
                    if (bidx_q == BIDX_W'(BPE-1)) begin
                        bidx_d = '0;
                        if (elem_q == ELEM_W'(N_ELEM-1)) begin
                            state_d = ST_CHECKSUM;
                        end else begin
                            elem_d = elem_q + ELEM_W'(1);
                        end
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end
            end
            default: begin
                if (handshake) begin
                    done_d = 1'b1;
                    // A capture landing on the final handshake starts the next frame directly.
                    if (res_valid) begin
                        snap_d  = res_data;
                        csum_d  = 8'h00;
                        elem_d  = '0;
                        bidx_d  = '0;
                        state_d = ST_HEADER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (res_valid) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            elem_q    <= '0;
            bidx_q    <= '0;
            csum_q    <= 8'h00;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            elem_q    <= elem_d;
            bidx_q    <= bidx_d;
            csum_q    <= csum_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_sys_array_result_serializer.sv
// Directed bench for the result serializer: framing, stalls, overrun,
// back-to-back capture, asynchronous abort and snapshot isolation.
module tb_sys_array_result_serializer;

    typedef logic [0:1][0:1][15:0] mat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       res_valid;
    mat_t       res_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         stab_err;
    int         done_early;
    int         last_cycles;
    mat_t       inject_data;

    mat_t rd1 = {16'h1234, 16'h0056, 16'hABCD, 16'h00FF};
    mat_t rd2 = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    mat_t rdc = {16'h0102, 16'h0304, 16'h0506, 16'h0708};
    mat_t rdf = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    logic [7:0] exp1[10] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h56, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hE9};
    logic [7:0] exp2[10] = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    logic [7:0] expc[10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};

    sys_array_result_serializer #(
        .DATA_WIDTH(8),
        .ARRAY_W_W (2),
        .ARRAY_A_L (2),
        .HEADER    (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .res_valid(res_valid),
        .res_data (res_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Runs from a negedge: picks tx_ready, optionally injects a capture on handshake
    // number inj_hs, records accepted bytes. Ends on the negedge after the n-th handshake.
    task automatic collect(input int n, input int rmode, input int inj_hs, input bit scr);
        int   cyc = 0;
        int   c_stall = 0;
        bit   prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        bit   rdy;
        rx_q.delete();
        stab_err   = 0;
        done_early = 0;
        while (rx_q.size() < n && cyc < 300) begin
            if (rmode == 0) begin
                rdy = 1'b1;
            end else if (rx_q.size() == n - 1 && c_stall < 5) begin
                rdy = 1'b0;
                c_stall++;
            end else begin
                rdy = (cyc % 3 == 0);
            end
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stab_err++;
            if (cyc > 0 && done === 1'b1) done_early++;
            res_valid = (tx_valid === 1'b1) && rdy && (rx_q.size() == inj_hs);
            if (res_valid) res_data = inject_data;
            else if (scr) res_data = {$urandom, $urandom};
            tx_ready = rdy;
            if (tx_valid === 1'b1 && rdy) rx_q.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !rdy;
            prev_data  = tx_data;
            cyc++;
            @(negedge clk);
        end
        res_valid   = 1'b0;
        tx_ready    = 1'b0;
        last_cycles = cyc;
        checks++;
        if (rx_q.size() != n) begin
            errors++;
            $display("FAIL collect_timeout: got %0d bytes, required %0d", rx_q.size(), n);
        end
    endtask

    task automatic capture(input mat_t d);
        res_valid = 1'b1;
        res_data  = d;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        res_valid = 1'b0;
        tx_ready  = 1'b0;
        res_data  = '0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_basic_frame();
        capture(rd1);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_capture: got %b, required 1", busy); end
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL basic_header_latency: got valid=%b data=%h, required 1/A5", tx_valid, tx_data);
        end
        collect(10, 0, -1, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL basic_byte%0d: got %h, required %h", i, rx_q[i], exp1[i]); end
        end
        checks += 5;
        if (last_cycles != 10) begin errors++; $display("FAIL basic_cycles: got %0d, required 10", last_cycles); end
        if (done_early != 0)   begin errors++; $display("FAIL basic_done_early: got %0d, required 0", done_early); end
        if (done !== 1'b1)     begin errors++; $display("FAIL basic_done_pulse: got %b, required 1", done); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy_end: got %b, required 0", busy); end
        @(negedge clk);
        if (done !== 1'b0)     begin errors++; $display("FAIL basic_done_single: got %b, required 0", done); end
        $display("test_basic_frame: %0d bytes in %0d cycles", rx_q.size(), last_cycles);
    endtask

    task automatic test_stall();
        capture(rd1);
        collect(10, 1, -1, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL stall_byte%0d: got %h, required %h", i, rx_q[i], exp1[i]); end
        end
        checks += 2;
        if (stab_err != 0) begin errors++; $display("FAIL stall_stability: got %0d violations, required 0", stab_err); end
        if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b, required 1", done); end
        @(negedge clk);
        $display("test_stall: %0d bytes in %0d cycles", rx_q.size(), last_cycles);
    endtask

    task automatic test_back_to_back();
        inject_data = rd2;
        capture(rd1);
        collect(10, 0, 9, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL b2b_first_byte%0d: got %h, required %h", i, rx_q[i], exp1[i]); end
        end
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b, required 1", done); end
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_held: got %b, required 1", busy); end
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL b2b_next_header: got valid=%b data=%h, required 1/A5", tx_valid, tx_data);
        end
        collect(10, 0, -1, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== exp2[i]) begin errors++; $display("FAIL b2b_second_byte%0d: got %h, required %h", i, rx_q[i], exp2[i]); end
        end
        checks += 2;
        if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, required 0", overrun); end
        if (done !== 1'b1)    begin errors++; $display("FAIL b2b_second_done: got %b, required 1", done); end
        @(negedge clk);
        $display("test_back_to_back: second frame %0d bytes", rx_q.size());
    endtask

    task automatic test_overrun();
        inject_data = rdf;
        capture(rd1);
        collect(10, 0, 3, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL ovr_byte%0d: got %h, required %h", i, rx_q[i], exp1[i]); end
        end
        checks += 2;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b, required 1", overrun); end
        if (done !== 1'b1)    begin errors++; $display("FAIL ovr_done: got %b, required 1", done); end
        repeat (3) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, required 1", overrun); end
        capture(rdc);
        collect(10, 0, -1, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== expc[i]) begin errors++; $display("FAIL ovr_recapture_byte%0d: got %h, required %h", i, rx_q[i], expc[i]); end
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky_after: got %b, required 1", overrun); end
        @(negedge clk);
        $display("test_overrun: overrun=%b", overrun);
    endtask

    task automatic test_async_reset();
        capture(rd1);
        collect(4, 0, -1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL abort_byte%0d: got %h, required %h", i, rx_q[i], exp1[i]); end
        end
        checks++;
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL abort_midframe_valid: got %b, required 1", tx_valid); end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL abort_tx_valid: got %b, required 0", tx_valid); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
        if (overrun !== 1'b0)  begin errors++; $display("FAIL abort_overrun: got %b, required 0", overrun); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL abort_tx_data: got %h, required 00", tx_data); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        capture(rd1);
        collect(10, 0, -1, 0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== exp1[i]) begin errors++; $display("FAIL abort_refresh_byte%0d: got %h, required %h", i, rx_q[i], exp1[i]); end
        end
        @(negedge clk);
        $display("test_async_reset: fresh frame %0d bytes", rx_q.size());
    endtask

    task automatic test_snapshot();
        capture(rdc);
        collect(10, 1, -1, 1);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rx_q[i] !== expc[i]) begin errors++; $display("FAIL snap_byte%0d: got %h, required %h", i, rx_q[i], expc[i]); end
        end
        @(negedge clk);
        $display("test_snapshot: %0d bytes with changing res_data", rx_q.size());
    endtask

    initial begin
        reset       = 1'b1;
        res_valid   = 1'b0;
        res_data    = '0;
        tx_ready    = 1'b0;
        inject_data = '0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_async_reset();
        test_snapshot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
